// File: rtl/cpu_sequencer.sv
// cpu_sequencer
//   Program sequencer for the 9-bit-instruction 4-bit CPU. Holds a small
//   loadable program memory and issues one word per cycle to the CPU.
//   When it is not issuing a real word it drives NOP (AND $0,$0,$0 = 0).
//
// Ports
//   CLK, RST     clock; synchronous active-high reset
//   LdEn/LdAddr/LdData   program-memory write port, accepted in IDLE only
//   Start        begin execution at address 0, accepted in IDLE only
//   Abort        stop execution, RUN only (wins over issue)
//   StepMode     1 = issue only on cycles where Step is high
//   Step         single-step request
//   Instruction  registered word to the CPU (NOP when not issuing)
//   InstrValid   Instruction holds a real program word this cycle
//   PC           address of the next word to fetch
//   IssueCount   number of words issued since the last Start
//   Busy, Done   decode of the FSM state (RUN, DONE); IDLE is neither.
//
// Handshake: Start is a request sampled on a rising edge while IDLE; it
// is not queued. Busy rises after that edge. Done is a one-cycle pulse
// that marks the end of a run, after which the sequencer is IDLE again.
module cpu_sequencer #(
  parameter int AW    = 4,
  parameter int DEPTH = 16,
  parameter int IW    = 9
) (
  input  logic          CLK,
  input  logic          RST,
  input  logic          LdEn,
  input  logic [AW-1:0] LdAddr,
  input  logic [IW-1:0] LdData,
  input  logic          Start,
  input  logic          Abort,
  input  logic          StepMode,
  input  logic          Step,
  output logic [IW-1:0] Instruction,
  output logic          InstrValid,
  output logic [AW-1:0] PC,
  output logic [AW:0]   IssueCount,
  output logic          Busy,
  output logic          Done
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  localparam logic [IW-1:0] NOP       = '0;
  localparam logic [2:0]    OP_HALT   = 3'b101;
  localparam logic [AW-1:0] LAST_ADDR = AW'(DEPTH - 1);

  state_t        state_q, state_d;
  logic [AW-1:0] pc_q, pc_d;
  logic [IW-1:0] instr_q, instr_d;
  logic          valid_q, valid_d;
  logic [AW:0]   cnt_q, cnt_d;
  // Set when the last memory word has been issued. The run then ends on
  // the following edge, so the last word is seen on Instruction for a full
  // cycle before DONE, and DONE itself always shows NOP.
  logic          end_q, end_d;
  logic          mem_we;

  logic [IW-1:0] mem [DEPTH];
  logic [IW-1:0] fetch_word;
  logic          issue;

  assign fetch_word = mem[pc_q];
  assign issue      = !StepMode || Step;

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    instr_d = NOP;
    valid_d = 1'b0;
    cnt_d   = cnt_q;
    end_d   = end_q;
    mem_we  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        mem_we = LdEn;
        if (Start) begin
          state_d = ST_RUN;
          pc_d    = '0;
          cnt_d   = '0;
          end_d   = 1'b0;
        end
      end
      ST_RUN: begin
        if (Abort || end_q) begin
          state_d = ST_DONE;
        end else if (issue) begin
          if (fetch_word[IW-1 -: 3] == OP_HALT) begin
            // HALT is undefined on the CPU, so it is never forwarded.
            state_d = ST_DONE;
          end else begin
            instr_d = fetch_word;
            valid_d = 1'b1;
            cnt_d   = cnt_q + 1'b1;
            if (pc_q == LAST_ADDR) end_d = 1'b1;  // no wrap, PC holds
            else                   pc_d  = pc_q + 1'b1;
          end
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q <= ST_IDLE;
      pc_q    <= '0;
      instr_q <= NOP;
      valid_q <= 1'b0;
      cnt_q   <= '0;
      end_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      instr_q <= instr_d;
      valid_q <= valid_d;
      cnt_q   <= cnt_d;
      end_q   <= end_d;
    end
  end

  // Program memory has no reset; a write in the Start cycle lands before
  // the first fetch one edge later.
  always_ff @(posedge CLK) begin
    if (mem_we && !RST) mem[LdAddr] <= LdData;
  end

  assign Instruction = instr_q;
  assign InstrValid  = valid_q;
  assign PC          = pc_q;
  assign IssueCount  = cnt_q;
  assign Busy        = (state_q == ST_RUN);
  assign Done        = (state_q == ST_DONE);

endmodule
